// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring algorithm, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in a single cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             KILL,
    input  logic [2:0]       FUNCT3,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [4:0]       RD_IN,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] RESULT,
    output logic [4:0]       RD_OUT
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t state, state_next;

    logic             accept;
    logic             op_signed;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;

    logic             is_rem_q;
    logic             special_q;
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       rd_out_q;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_signed = ~FUNCT3[0];
    assign accept    = (state == IDLE) && START && FUNCT3[2] && !KILL;
    assign div_zero  = (DATA2 == '0);
    assign overflow  = op_signed && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
    assign abs1      = op_signed ? abs_val($signed(DATA1)) : DATA1;
    assign abs2      = op_signed ? abs_val($signed(DATA2)) : DATA2;

    // The top bit of the trial difference is the borrow: set means the divisor did not fit.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, divisor_q};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (div_zero || overflow) ? FINISH : CALC;
                end
            end
            CALC: begin
                if (KILL) begin
                    state_next = IDLE;
                end else if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            is_rem_q   <= 1'b0;
            special_q  <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rd_q       <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                is_rem_q   <= FUNCT3[1];
                rd_q       <= RD_IN;
                cnt_q      <= '0;
                neg_quot_q <= op_signed && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
                neg_rem_q  <= op_signed && DATA1[WIDTH-1];
                special_q  <= div_zero || overflow;
                divisor_q  <= abs2;
                if (div_zero) begin
                    quot_q <= '1;
                    rem_q  <= DATA1;
                end else if (overflow) begin
                    quot_q <= DATA1;
                    rem_q  <= '0;
                end else begin
                    quot_q <= abs1;
                    rem_q  <= '0;
                end
            end else if (state == CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!rem_trial[WIDTH]) begin
                    rem_q  <= rem_trial[WIDTH-1:0];
                    quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q  <= rem_shift[WIDTH-1:0];
                    quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                end
            end else if ((state == FINISH) && !KILL) begin
                valid_q  <= 1'b1;
                rd_out_q <= rd_q;
                if (is_rem_q) begin
                    result_q <= special_q ? rem_q : sign_fix(rem_q, neg_rem_q);
                end else begin
                    result_q <= special_q ? quot_q : sign_fix(quot_q, neg_quot_q);
                end
            end
        end
    end

    assign BUSY   = (state != IDLE);
    assign VALID  = valid_q;
    assign RESULT = result_q;
    assign RD_OUT = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, checked when VALID pulses.
module tb_div_unit;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        KILL = 1'b0;
    logic [2:0]  FUNCT3 = '0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [4:0]  RD_IN = '0;
    logic        BUSY;
    logic        VALID;
    logic [31:0] RESULT;
    logic [4:0]  RD_OUT;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    div_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .KILL(KILL), .FUNCT3(FUNCT3),
        .DATA1(DATA1), .DATA2(DATA2), .RD_IN(RD_IN), .BUSY(BUSY), .VALID(VALID),
        .RESULT(RESULT), .RD_OUT(RD_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
        case (f3[1:0])
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (RESET && VALID) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("result", RESULT, mon_e.res);
                check_val("rd_out", {27'd0, RD_OUT}, {27'd0, mon_e.rd});
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit push);
        FUNCT3 = f3;
        DATA1  = a;
        DATA2  = b;
        RD_IN  = rd;
        START  = 1'b1;
        if (push) sb_q.push_back('{res: exp, rd: rd});
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat, input int exp_busy);
        int lat = 0;
        int busy = 0;
        while (!VALID && lat < 100) begin
            if (BUSY) busy++;
            @(negedge CLK);
            lat++;
        end
        check_val("latency", lat, exp_lat);
        check_val("busy_cycles", busy, exp_busy);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat);
        issue(f3, a, b, rd, exp, 1'b1);
        wait_valid(lat, lat);
        @(negedge CLK);
        check_val("valid_pulse", {31'd0, VALID}, 32'd0);
    endtask

    initial begin
        #3;
        check_val("rst_busy", {31'd0, BUSY}, 32'd0);
        check_val("rst_valid", {31'd0, VALID}, 32'd0);
        check_val("rst_result", RESULT, 32'd0);
        check_val("rst_rd", {27'd0, RD_OUT}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // START with FUNCT3[2]=0 must be ignored
        FUNCT3 = 3'b001; DATA1 = 32'd10; DATA2 = 32'd3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check_val("ignore_nonm_busy", {31'd0, BUSY}, 32'd0);

        run_op(F_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run_op(F_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
        run_op(F_DIV,  32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFA, 33);
        run_op(F_REM,  32'hFFFF_FFEC, 32'd3, 5'd8, 32'hFFFF_FFFE, 33);
        run_op(F_REM,  32'd20, 32'hFFFF_FFFD, 5'd9, 32'd2, 33);
        run_op(F_DIV,  32'h7FFF_FFFF, 32'd1, 5'd10, 32'h7FFF_FFFF, 33);
        run_op(F_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
        run_op(F_REM,  32'd5, 32'd0, 5'd12, 32'd5, 1);
        run_op(F_DIV,  32'hFFFF_FFFF, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
        run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
        run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd16, 32'hFFFF_FFFF, 33);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 32'd0) b = 32'd3;
            run_op(f3, a, b, 5'(i + 20), model(f3, a, b), 33);
        end

        // START while busy is dropped; the original result comes back intact
        issue(F_DIVU, 32'd1000, 32'd10, 5'd3, 32'd100, 1'b1);
        repeat (10) @(negedge CLK);
        FUNCT3 = F_REMU; DATA1 = 32'd7; DATA2 = 32'd0; RD_IN = 5'd9; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_valid(22, 22);
        @(negedge CLK);

        // KILL mid-CALC: no VALID, outputs keep the previous result
        issue(F_DIV, 32'd77, 32'd5, 5'd17, 32'd0, 1'b0);
        repeat (9) @(negedge CLK);
        KILL = 1'b1;
        @(negedge CLK);
        KILL = 1'b0;
        check_val("kill_busy", {31'd0, BUSY}, 32'd0);
        repeat (40) @(negedge CLK);
        check_val("kill_result_hold", RESULT, 32'd100);
        check_val("kill_rd_hold", {27'd0, RD_OUT}, 32'd3);

        // Back-to-back: second START lands in the VALID cycle of the first
        issue(F_DIVU, 32'd50, 32'd6, 5'd1, 32'd8, 1'b1);
        wait_valid(33, 33);
        issue(F_REMU, 32'd50, 32'd6, 5'd2, 32'd2, 1'b1);
        wait_valid(33, 33);
        @(negedge CLK);

        // Asynchronous reset between edges mid-CALC
        issue(F_DIVU, 32'd1234, 32'd11, 5'd4, 32'd0, 1'b0);
        repeat (11) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check_val("arst_busy", {31'd0, BUSY}, 32'd0);
        check_val("arst_valid", {31'd0, VALID}, 32'd0);
        check_val("arst_result", RESULT, 32'd0);
        check_val("arst_rd", {27'd0, RD_OUT}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        run_op(F_DIVU, 32'd9, 32'd2, 5'd18, 32'd4, 33);

        repeat (40) @(negedge CLK);
        check_val("sb_drain", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
